uart_rx: RTL and testbench

- Serial-to-parallel UART receiver; the receive-side counterpart of the uart_tx transmitter.
- Samples the asynchronous serial line with 8N1 framing: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Delivers each received byte as a single-cycle valid pulse on the axiov/axiod output.
- Sits between the board RX pin and the host-command parser of the nonogram solver.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 33 +++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver (uart_rx) and the transmitter
// (uart_tx): frame geometry, default clock/line rates and the receiver state
// encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Number of data bits carried in one frame (8N1 framing)
    localparam int DATA_BITS = 8;

    // Default board clock and line rate, shared by both link directions
    localparam int DEFAULT_CLK_HZ = 100_000_000;
    localparam int DEFAULT_BAUD   = 115_200;

    // Receiver FSM states. PARITY is only visited when parity checking is built in.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input. The reset value is a
// parameter so idle-high lines (such as a UART RX pin) do not appear to toggle
// when reset is released.
// Ports:
//   clk  in   destination clock
//   rst  in   asynchronous active-high reset (loads RST_VAL into both flops)
//   d    in   asynchronous input
//   q    out  synchronized output, two clk cycles behind d
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. The RX line is synchronized, the start bit is qualified at
// its mid-point, then each data bit (LSB first) and the stop bit are sampled at
// their mid-points. A good frame produces a one-cycle axiov pulse with the byte
// on axiod (held until the next good byte). A low stop bit produces a one-cycle
// framing_err pulse and the receiver waits for the line to return high.
//
// Optional build macro UART_RX_PARITY_EN: inserts an even-parity bit between
// the data and stop bits; a parity mismatch pulses parity_err instead of axiov.
// Without the macro parity_err is tied low.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   axiid        in   serial RX line, idle high, asynchronous to clk
//   axiov        out  one-cycle pulse: axiod holds a newly received byte
//   axiod[7:0]   out  last good received byte
//   framing_err  out  one-cycle pulse: stop bit sampled low
//   parity_err   out  one-cycle pulse: parity mismatch (parity build only)
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int BAUD   = DEFAULT_BAUD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 axiid,
    output logic                 axiov,
    output logic [DATA_BITS-1:0] axiod,
    output logic                 framing_err,
    output logic                 parity_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    // Mid-bit point of the start bit, and full-bit interval for the rest
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLK_HZ/BAUD must be at least 4");
    end

    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (axiid),
        .q   (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            axiov       <= 1'b0;
            axiod       <= '0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            // Status outputs are single-cycle pulses
            axiov       <= 1'b0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        // Line back high at mid start bit: treat as a glitch
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_M1) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Return to IDLE at mid stop bit so a start bit
                            // directly following the stop bit is not missed
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (^{shift, par_bit}) begin
                                parity_err <= 1'b1;
                            end else begin
                                axiov <= 1'b1;
                                axiod <= shift;
                            end
`else
                            axiov <= 1'b1;
                            axiod <= shift;
`endif
                        end else begin
                            framing_err <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    // A held-low (break) line parks here without further errors
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at CLK_HZ=1_000_000, BAUD=125_000 (8 clocks
// per bit, 10-unit clock period). Serial frames are generated with time delays
// so the bit period need not be a whole number of clocks. A reference model
// decides, from the frame's bits alone, whether each frame should yield a byte,
// a framing error or a parity error.
// -----------------------------------------------------------------------------
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    localparam int NOM = 80;   // nominal bit period in time units (8 clocks)

    logic       clk = 1'b0;
    logic       rst;
    logic       axiid;
    logic       axiov;
    logic [7:0] axiod;
    logic       framing_err;
    logic       parity_err;

    int total = 0;
    int bad   = 0;

    // Observed events
    logic [7:0] got_q[$];
    int ferr_seen = 0;
    int perr_seen = 0;
    int overlap   = 0;
    int wide      = 0;
    logic prev_ov = 1'b0;

    // Expected events
    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    int exp_perr = 0;
    int chk_idx  = 0;

    uart_rx #(
        .CLK_HZ (1_000_000),
        .BAUD   (125_000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axiid       (axiid),
        .axiov       (axiov),
        .axiod       (axiod),
        .framing_err (framing_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (axiov) got_q.push_back(axiod);
            if (framing_err) ferr_seen <= ferr_seen + 1;
            if (parity_err) perr_seen <= perr_seen + 1;
            if (axiov && framing_err) overlap <= overlap + 1;
            if (axiov && prev_ov) wide <= wide + 1;
            prev_ov <= axiov;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: 0 = byte delivered, 1 = framing error, 2 = parity error
    function automatic int outcome(input logic [7:0] d, input logic p, input logic stop);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (!stop) return 1;
        if (PEN && (((ones + int'(p)) % 2) != 0)) return 2;
        return 0;
    endfunction

    // Send one frame at bit period 'per'; par_ok selects a correct even-parity bit
    task automatic frame(input logic [7:0] d, input int per, input bit par_ok, input bit stop);
        logic p;
        int   r;
        int   ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        p = ((ones % 2) != 0) ? par_ok : !par_ok;
        r = outcome(d, p, stop);
        if (r == 0) exp_q.push_back(d);
        else if (r == 1) exp_ferr++;
        else exp_perr++;
        axiid = 1'b0;
        #(per);
        for (int i = 0; i < 8; i++) begin
            axiid = d[i];
            #(per);
        end
        if (PEN) begin
            axiid = p;
            #(per);
        end
        axiid = stop;
        #(per);
        axiid = 1'b1;
    endtask

    // Compare everything observed since the previous checkpoint
    task automatic check_step(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = chk_idx; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk({tag, "_byte"}, int'(got_q[i]), int'(exp_q[i]));
        end
        chk_idx = exp_q.size();
        chk({tag, "_ferr"}, ferr_seen, exp_ferr);
        chk({tag, "_perr"}, perr_seen, exp_perr);
        chk({tag, "_overlap"}, overlap, 0);
        chk({tag, "_width"}, wide, 0);
    endtask

    initial begin
        logic [7:0] c3;
        logic [7:0] rb;
        int         per;
        int         gap;
        bit         stp;
        bit         pok;

        // Reset state
        rst   = 1'b1;
        axiid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_axiov", int'(axiov), 0);
        chk("rst_axiod", int'(axiod), 0);
        chk("rst_ferr", int'(framing_err), 0);
        chk("rst_perr", int'(parity_err), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Back-to-back frames
        frame(8'hA5, NOM, 1'b1, 1'b1);
        frame(8'h3C, NOM, 1'b1, 1'b1);
        #(2 * NOM);
        check_step("b2b");

        // Short low glitch on the idle line, then a real frame
        @(negedge clk);
        axiid = 1'b0;
        #20;
        axiid = 1'b1;
        #200;
        check_step("glitch");
        frame(8'h55, NOM, 1'b1, 1'b1);
        #(2 * NOM);
        check_step("after_glitch");

        // Low stop bit followed by a 40-cycle break
        frame(8'hFF, NOM, 1'b1, 1'b0);
        axiid = 1'b0;
        #400;
        axiid = 1'b1;
        #(2 * NOM);
        check_step("break");
        frame(8'h01, NOM, 1'b1, 1'b1);
        #(2 * NOM);
        check_step("after_break");

        // Reset during data bit 4 of 8'hC3
        c3 = 8'hC3;
        @(negedge clk);
        axiid = 1'b0;
        #(NOM);
        for (int i = 0; i < 4; i++) begin
            axiid = c3[i];
            #(NOM);
        end
        axiid = c3[4];
        #(NOM / 2);
        rst   = 1'b1;
        axiid = 1'b1;
        #3;
        chk("midrst_axiod", int'(axiod), 0);
        chk("midrst_axiov", int'(axiov), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #(12 * NOM);
        check_step("aborted");
        frame(8'h81, NOM, 1'b1, 1'b1);
        #(2 * NOM);
        check_step("after_rst");

        // Baud mismatch within the receiver's tolerance, slow then fast
        frame(8'h5A, 82, 1'b1, 1'b1);
        #(2 * NOM);
        frame(8'h5A, 78, 1'b1, 1'b1);
        #(2 * NOM);
        check_step("skew");

        if (PEN) begin
            frame(8'h07, NOM, 1'b1, 1'b1);
            #(2 * NOM);
            frame(8'h07, NOM, 1'b0, 1'b1);
            #(2 * NOM);
            check_step("parity");
        end

        // Random frames: random bytes, small rate offsets, occasional bad stop/parity
        for (int n = 0; n < 16; n++) begin
            rb  = 8'($urandom);
            per = $urandom_range(79, 81);
            stp = ($urandom_range(0, 4) != 0);
            pok = ($urandom_range(0, 3) != 0);
            gap = stp ? $urandom_range(0, 2) : $urandom_range(1, 2);
            frame(rb, per, pok, stp);
            #(gap * per);
        end
        #(2 * NOM);
        check_step("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
